// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and constants for the debug scan monitor.
//   scan_st_e  - scanner FSM states
//   rate_e     - tick rate encodings for rate_sel_i
//   END_MARKER - word shown after the last index of a channel (all-ones);
//                sliced to DATA_W, so DATA_W must not exceed 64
//   CH_*       - read channel numbers used by the core's board top
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_SHOW  = 2'd3
  } scan_st_e;

  typedef enum logic [1:0] {
    RATE_SLOW = 2'd0,  // tick when counter[DIV_W-1:0] is all ones
    RATE_MED  = 2'd1,  // tick when counter[DIV_W-3:0] is all ones
    RATE_FAST = 2'd2,  // tick when counter[DIV_W-5:0] is all ones
    RATE_SIM  = 2'd3   // tick every cycle
  } rate_e;

  localparam logic [63:0] END_MARKER = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int CH_IM  = 0;
  localparam int CH_RF  = 1;
  localparam int CH_ALU = 2;
  localparam int CH_DM  = 3;

endpackage

// File: rtl/dbg_scan_monitor_if.sv
// dbg_scan_monitor_if: synchronous debug read port between the scan monitor
// (master) and the core's debug read mux (slave).
//   rd_en_o   - read strobe
//   rd_ch_o   - channel being read
//   rd_addr_o - index being read
//   rd_data_i - read data, valid exactly one cycle after rd_en_o
interface dbg_scan_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              rd_en_o;
  logic [CH_W-1:0]   rd_ch_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;

  modport master (output rd_en_o, output rd_ch_o, output rd_addr_o, input rd_data_i);
  modport slave  (input rd_en_o, input rd_ch_o, input rd_addr_o, output rd_data_i);
endinterface

// File: rtl/dbg_step_sync.sv
// dbg_step_sync: turns the raw, asynchronous step button into a single
// one-cycle pulse per press.
//   clk, rstn - clock, asynchronous active-low reset
//   step_i    - raw button level
//   pulse_o   - one-cycle pulse on the rising edge of the (filtered) level
// Build option DBG_DEBOUNCE_EN: the synchronised level must hold for 2^DB_W
// consecutive cycles before the filtered level follows it.
module dbg_step_sync #(
  parameter int DB_W = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic step_i,
  output logic pulse_o
);
  logic s1_q, s2_q, lvl, lvl_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= step_i;
      s2_q <= s1_q;
    end
  end

`ifdef DBG_DEBOUNCE_EN
  logic [DB_W-1:0] db_cnt_q;
  logic            filt_q;

  // Counter runs only while the input disagrees with the filtered level;
  // any return to agreement restarts the stability window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b0;
    end else if (s2_q == filt_q) begin
      db_cnt_q <= '0;
    end else if (&db_cnt_q) begin
      filt_q   <= s2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  // DB_W only sizes the filter counter; a zero width would be meaningless.
  if (DB_W < 1) begin : g_db_w_invalid
  end

  assign lvl = s2_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lvl_q <= 1'b0;
    else       lvl_q <= lvl;
  end

  assign pulse_o = lvl & ~lvl_q;
endmodule

// File: rtl/dbg_scan_monitor.sv
// dbg_scan_monitor: walks an index over one of NUM_CH debug read channels,
// reads each word through a one-cycle synchronous port and hands it to the
// 7-segment driver; also generates the CPU clock-enable (free-run or step).
//   clk, rstn    - clock, asynchronous active-low reset
//   scan_en_i    - allow a new read on each tick
//   cpu_run_i    - 1: cpu_en_o follows the tick; 0: one pulse per step press
//   step_i       - raw step button
//   rate_sel_i   - tick rate (dbg_pkg::rate_e)
//   ch_sel_i     - one-hot channel select (none/multiple -> channel 0)
//   ch_last_i    - last valid index per channel, ADDR_W bits each
//   rd           - debug read port (master side)
//   disp_data_o  - displayed word; all-ones marks end of a channel
//   disp_upd_o   - one-cycle pulse when disp_data_o is loaded
//   idx_o        - current scan index
//   cpu_en_o     - one-cycle CPU clock-enable
// Build option DBG_DEBOUNCE_EN enables the step button debouncer.
module dbg_scan_monitor
  import dbg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DIV_W  = 28,
  parameter int DB_W   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     scan_en_i,
  input  logic                     cpu_run_i,
  input  logic                     step_i,
  input  logic [1:0]               rate_sel_i,
  input  logic [NUM_CH-1:0]        ch_sel_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_last_i,
  dbg_scan_monitor_if.master       rd,
  output logic [DATA_W-1:0]        disp_data_o,
  output logic                     disp_upd_o,
  output logic [ADDR_W-1:0]        idx_o,
  output logic                     cpu_en_o
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [DATA_W-1:0] MARK = DATA_W'(END_MARKER);

  logic [DIV_W-1:0]  div_q, div_mask;
  logic              tick, step_pls;
  logic [CH_W-1:0]   ch_act, ch_q;
  logic              ch_chg;
  logic [ADDR_W-1:0] idx_q, last_sel;
  logic              end_q;
  scan_st_e          st_q, st_d;

  // ---- divider / tick ----
  always_comb begin
    div_mask = '0;
    case (rate_e'(rate_sel_i))
      RATE_SLOW: div_mask = {DIV_W{1'b1}};
      RATE_MED:  div_mask = {DIV_W{1'b1}} >> 2;
      RATE_FAST: div_mask = {DIV_W{1'b1}} >> 4;
      default:   div_mask = '0;  // empty mask: tick every cycle
    endcase
  end

  assign tick = ((div_q & div_mask) == div_mask);

  // ---- channel decode ----
  always_comb begin
    ch_act = '0;
    if ($onehot(ch_sel_i))
      for (int c = 0; c < NUM_CH; c++)
        if (ch_sel_i[c]) ch_act = CH_W'(c);
  end

  // A change is seen against the registered channel, so the abort lands
  // on the same edge that adopts the new channel.
  assign ch_chg   = (ch_act != ch_q);
  assign last_sel = ch_last_i[int'(ch_q)*ADDR_W +: ADDR_W];

  // ---- scanner FSM ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st_q <= ST_IDLE;
    else       st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE:  if (tick && scan_en_i) st_d = ST_ISSUE;
      ST_ISSUE: st_d = ST_WAIT;
      ST_WAIT:  st_d = ST_SHOW;
      ST_SHOW:  st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
    if (ch_chg) st_d = ST_IDLE;
  end

  // The end-marker pass walks the same states so every display update keeps
  // the same tick-to-update timing; it just skips the read strobe.
  assign rd.rd_en_o   = (st_q == ST_ISSUE) && !end_q;
  assign rd.rd_ch_o   = ch_q;
  assign rd.rd_addr_o = idx_q;
  assign idx_o        = idx_q;

  // ---- datapath ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q       <= '0;
      ch_q        <= '0;
      idx_q       <= '0;
      end_q       <= 1'b0;
      disp_data_o <= MARK;
      disp_upd_o  <= 1'b0;
      cpu_en_o    <= 1'b0;
    end else begin
      div_q      <= div_q + 1'b1;
      ch_q       <= ch_act;
      cpu_en_o   <= cpu_run_i ? tick : step_pls;
      disp_upd_o <= 1'b0;
      if (ch_chg) begin
        idx_q <= '0;
        end_q <= 1'b0;
      end else begin
        if (st_q == ST_WAIT) begin
          disp_data_o <= end_q ? MARK : rd.rd_data_i;
          disp_upd_o  <= 1'b1;
        end
        if (st_q == ST_SHOW) begin
          if (end_q) begin
            idx_q <= '0;
            end_q <= 1'b0;
          end else if (idx_q >= last_sel) begin
            end_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
      end
    end
  end

  dbg_step_sync #(.DB_W(DB_W)) u_step (
    .clk     (clk),
    .rstn    (rstn),
    .step_i  (step_i),
    .pulse_o (step_pls)
  );
endmodule
